// File: rtl/icebreaker_ui_pkg.sv
// Shared encodings for the iCE40 button/LED user-interface block: display modes
// and the roles of the first three buttons in the COUNT and PWM modes.
package icebreaker_ui_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  localparam int unsigned BTN_INC = 0;
  localparam int unsigned BTN_DEC = 1;
  localparam int unsigned BTN_CLR = 2;

  // Widest supported button vector; role lookups are made on a vector padded to this.
  localparam int unsigned MAX_BTN = 8;

endpackage

// File: rtl/icebreaker_btn_led_ctrl_if.sv
// Button/LED bundle between a board top level (master) and the UI controller (slave).
interface icebreaker_btn_led_ctrl_if #(
    parameter int unsigned NUM_BTN = 3,
    parameter int unsigned NUM_LED = 5
);

    logic [1:0]         mode;
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] long_press;
    logic [NUM_LED-1:0] led_out;

    modport master (
        output mode,
        output btn_in,
        input  btn_stable,
        input  btn_press,
        input  long_press,
        input  led_out
    );

    modport slave (
        input  mode,
        input  btn_in,
        output btn_stable,
        output btn_press,
        output long_press,
        output led_out
    );

endinterface

// File: rtl/icebreaker_btn_led_ctrl_debounce.sv
// One button channel: polarity fix, 2-flop sync, debounce, press pulse and, with
// ICEBREAKER_BTN_LONGPRESS_EN defined, a saturating hold counter for long presses.
module btn_debounce #(
    parameter logic        INVERT    = 1'b0,
    parameter int unsigned DB_LIMIT  = 12000,
    parameter int unsigned DB_BITS   = 16,
    parameter int unsigned LONG_BITS = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable,
    output logic press,
    output logic long_press
);

    localparam logic [DB_BITS-1:0] CNT_LAST = DB_BITS'(DB_LIMIT - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic [DB_BITS-1:0] cnt_q;
    logic               stable_q;
    logic               press_q;
    logic               flip;

    // The window completes on the edge where the counter already shows DB_LIMIT-1.
    assign flip = (sync2_q != stable_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw ^ INVERT;
            sync2_q <= sync1_q;
            if ((sync2_q == stable_q) || flip) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flip) begin
                stable_q <= ~stable_q;
            end
            press_q <= flip & ~stable_q;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

`ifdef ICEBREAKER_BTN_LONGPRESS_EN
    localparam logic [LONG_BITS-1:0] HOLD_PRE_SAT = {{(LONG_BITS-1){1'b1}}, 1'b0};

    logic [LONG_BITS-1:0] hold_q;
    logic                 long_q;

    // Saturation makes the all-ones match, and hence the pulse, happen once per hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            if (!stable_q) begin
                hold_q <= '0;
            end else if (hold_q != '1) begin
                hold_q <= hold_q + 1'b1;
            end
            long_q <= stable_q && (hold_q == HOLD_PRE_SAT);
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/icebreaker_btn_led_ctrl.sv
// Board UI block: NUM_BTN debounced buttons driving NUM_LED registered LEDs in
// DIRECT, TOGGLE, COUNT or PWM mode. Long-press support: ICEBREAKER_BTN_LONGPRESS_EN.
module icebreaker_btn_led_ctrl
    import icebreaker_ui_pkg::*;
#(
    parameter int unsigned        NUM_BTN    = 3,
    parameter int unsigned        NUM_LED    = 5,
    parameter logic [NUM_BTN-1:0] BTN_INVERT = NUM_BTN'(3'b001),
    parameter int unsigned        DB_LIMIT   = 12000,
    parameter int unsigned        DB_BITS    = 16,
    parameter int unsigned        PWM_BITS   = 4,
    parameter int unsigned        LONG_BITS  = 24
) (
    input logic                      clk,
    input logic                      rst,
    icebreaker_btn_led_ctrl_if.slave bus
);

    logic [NUM_BTN-1:0]  stable;
    logic [NUM_BTN-1:0]  press;
    logic [NUM_BTN-1:0]  long_p;
    logic [MAX_BTN-1:0]  press_ext;
    logic                inc;
    logic                dec;
    logic                clr;
    mode_e               mode;

    logic [NUM_BTN-1:0]  tog_q, tog_d;
    logic [NUM_LED-1:0]  count_q, count_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [NUM_LED-1:0]  led_q, led_d;
    logic [NUM_LED-1:0]  stable_map;
    logic [NUM_LED-1:0]  tog_map;
    logic                pwm_on;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .INVERT    (BTN_INVERT[g]),
            .DB_LIMIT  (DB_LIMIT),
            .DB_BITS   (DB_BITS),
            .LONG_BITS (LONG_BITS)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (bus.btn_in[g]),
            .stable     (stable[g]),
            .press      (press[g]),
            .long_press (long_p[g])
        );
    end

    // Roles beyond the last fitted button read as never pressed.
    always_comb begin
        press_ext = '0;
        press_ext[NUM_BTN-1:0] = press;
    end

    assign inc  = press_ext[BTN_INC];
    assign dec  = press_ext[BTN_DEC];
    assign clr  = press_ext[BTN_CLR];
    assign mode = mode_e'(bus.mode);

    always_comb begin
        tog_d   = tog_q;
        count_d = count_q;
        level_d = level_q;
        case (mode)
            MODE_TOGGLE: begin
                tog_d = (|long_p) ? '0 : (tog_q ^ press);
            end
            MODE_COUNT: begin
                if (clr) begin
                    count_d = '0;
                end else if (inc && !dec) begin
                    count_d = count_q + 1'b1;
                end else if (dec && !inc) begin
                    count_d = count_q - 1'b1;
                end
            end
            MODE_PWM: begin
                if (inc && !dec && (level_q != '1)) begin
                    level_d = level_q + 1'b1;
                end else if (dec && !inc && (level_q != '0)) begin
                    level_d = level_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // LED i follows button i mod NUM_BTN in the per-button modes.
    for (genvar g = 0; g < NUM_LED; g++) begin : g_map
        assign stable_map[g] = stable[g % NUM_BTN];
        assign tog_map[g]    = tog_d[g % NUM_BTN];
    end

    assign pwm_on = (pwm_cnt_q < level_d);

    always_comb begin
        led_d = '0;
        case (mode)
            MODE_DIRECT: led_d = stable_map;
            MODE_TOGGLE: led_d = tog_map;
            MODE_COUNT:  led_d = count_d;
            MODE_PWM:    led_d = {NUM_LED{pwm_on}};
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog_q     <= '0;
            count_q   <= '0;
            level_q   <= '0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            tog_q     <= tog_d;
            count_q   <= count_d;
            level_q   <= level_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            led_q     <= led_d;
        end
    end

    assign bus.btn_stable = stable;
    assign bus.btn_press  = press;
    assign bus.long_press = long_p;
    assign bus.led_out    = led_q;

endmodule

// File: doc/icebreaker_btn_led_ctrl.md
Name: icebreaker_btn_led_ctrl

Overview:
Parametrised board user-interface block for iCE40 boards. It takes NUM_BTN raw button pins, already through input SB_IOs, and for each one synchronises, debounces and edge-detects it. It drives NUM_LED registered LED outputs in one of four run-time modes: direct, toggle, counter and PWM brightness. It sits directly behind the pad SB_IOs in board top levels and replaces hand-wired button-to-LED assigns.

Parameters:
NUM_BTN, 3, number of button channels (1..8)
NUM_LED, 5, number of LED outputs (1..8)
BTN_INVERT, 3'b001, per-button polarity mask; bit i set means button i is active-low at the pin
DB_LIMIT, 16'd12000, debounce stability window in clk cycles (>=2)
DB_BITS, 16, debounce counter width; must hold DB_LIMIT
PWM_BITS, 4, brightness resolution
LONG_BITS, 24, long-press counter width (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
mode  input  2  display mode; sampled every cycle
btn_in  input  NUM_BTN  raw button levels from pad SB_IOs
btn_stable  output  NUM_BTN  debounced, polarity-corrected level; 1 = pressed
btn_press  output  NUM_BTN  one-cycle pulse on a debounced press
long_press  output  NUM_BTN  one-cycle long-hold pulse; constant 0 without the optional feature
led_out  output  NUM_LED  registered LED drive; 1 = lit

Behaviour:
- Reset: one clock, clk. Asynchronous, active-high reset on rst. All flops clear to 0: sync, stable, counters, tog, count, level, pwm_cnt, led_out, btn_press, long_press.
- Sync: each btn_in bit is XORed with BTN_INVERT, then passed through a 2-flop synchroniser.
- Debounce, per channel:
  - sync != stable: counter increments.
  - Counter reaches DB_LIMIT-1 while still mismatched: stable flips on the next edge and the counter clears.
  - Any cycle with sync == stable clears the counter; glitches shorter than DB_LIMIT are rejected.
  - Total pin-to-btn_stable latency is DB_LIMIT+2 cycles.
- btn_press[i] is registered and high exactly in the first cycle btn_stable[i]=1. A release produces no pulse.
- Modes, with j = i mod NUM_BTN:
  - 0 DIRECT: led_out[i] = btn_stable[j].
  - 1 TOGGLE: tog[j] flips on btn_press[j]; led_out[i] = tog[j].
  - 2 COUNT: NUM_LED-bit count.
    - btn0 press: +1. btn1 press: -1. btn2 press: clear.
    - Wraps modulo 2^NUM_LED.
    - Same-cycle events: clear wins; +1 and -1 together leave count unchanged.
    - led_out = count.
  - 3 PWM: PWM_BITS level.
    - btn0 press: +1, saturating at 2^PWM_BITS-1. btn1 press: -1, saturating at 0.
    - pwm_cnt is a free-running PWM_BITS counter.
    - All LEDs = (pwm_cnt < level); level 0 means always off.
- tog, count and level update only while their own mode is selected. Changing mode does not clear them.
- led_out has one cycle of latency from btn_stable, btn_press or mode.
- Channels with NUM_BTN < 2 or < 3 simply have no inc/dec/clear source; the missing inputs are treated as 0.
- rst asserted mid-debounce or mid-hold aborts it; no press pulse is emitted after rst deasserts unless the full window elapses again.

Optional Feature:
ICEBREAKER_BTN_LONGPRESS_EN
- Defined: a per-channel LONG_BITS hold counter runs while btn_stable[i]=1.
  - When the counter saturates at all-ones, long_press[i] pulses once per hold.
  - The counter clears on release.
  - In TOGGLE mode, any long_press clears all tog bits; this takes priority over a same-cycle toggle.
- Undefined: no hold counters are synthesised and long_press is tied to 0.

Decomposition:
- Package icebreaker_ui_pkg holds:
  - the mode encoding: MODE_DIRECT=0, MODE_TOGGLE=1, MODE_COUNT=2, MODE_PWM=3;
  - the button role indices: BTN_INC=0, BTN_DEC=1, BTN_CLR=2.
- Sub-module btn_debounce: one channel covering invert, 2-flop sync, debounce counter, stable and press pulse, plus the optional hold counter. Instantiated NUM_BTN times with generate.

Test Plan:
Bench uses DB_LIMIT=8, PWM_BITS=4, LONG_BITS=5.
1. Mode 0, btn_in[1] rises and holds -> btn_stable[1]=1 exactly 10 cycles later, btn_press[1] pulses 1 cycle, led_out[1] and led_out[4] go to 1 one cycle later; btn_in[0] with pin held high -> btn_stable[0]=0.
2. Glitch: btn_in[2] high for 7 cycles, then low -> btn_stable[2] stays 0 and no press pulse.
3. Mode 2: three btn0 presses -> count=3. One btn1 press -> count=2. btn1 and btn2 pressed in the same cycle -> count=0. One btn1 press from 0 -> count=5'b11111.
4. Mode 3: 20 btn0 presses -> level saturates at 15 and led_out is high for 15 of every 16 cycles. Two btn1 presses -> 13 of 16.
5. Mode 1: press btn0 then btn0 again -> tog[0] goes 1 then 0. Assert rst mid-debounce -> all outputs 0 and no press after release.
6. ICEBREAKER_BTN_LONGPRESS_EN defined, mode 1: hold btn0 for 40 cycles -> exactly one long_press[0] pulse 31 cycles after stable, and all tog bits clear.
